ofdm_demapper_serializer: RTL

- Receive-path stage directly upstream of the deinterleaver.
- Accepts one equalized subcarrier sample (I/Q) per handshake and hard-slices it to NBPSC Gray-coded bits per the 802.11a constellations: BPSK, QPSK, 16-QAM, 64-QAM.
- Emits the bits serially, one per clock, in b0-first order, matching the deinterleaver's serial data/valid input.
- Counts 48 data subcarriers per OFDM symbol and flags the final coded bit of each symbol.

---
 rtl/ofdm_pkg.sv | 31 +++
 rtl/demap_axis_slicer.sv | 63 ++++++
 rtl/ofdm_demapper_serializer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared OFDM constants: modulation encodings, NSD, bits-per-subcarrier lookups
package ofdm_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'b00,
        MODE_QPSK  = 2'b01,
        MODE_QAM16 = 2'b10,
        MODE_QAM64 = 2'b11
    } mode_t;

    localparam int NSD = 48;

    function automatic logic [2:0] nbpsc(input mode_t m);
        case (m)
            MODE_BPSK:  nbpsc = 3'd1;
            MODE_QPSK:  nbpsc = 3'd2;
            MODE_QAM16: nbpsc = 3'd4;
            default:    nbpsc = 3'd6;
        endcase
    endfunction

    function automatic logic [8:0] ncbps(input mode_t m);
        case (m)
            MODE_BPSK:  ncbps = 9'd48;
            MODE_QPSK:  ncbps = 9'd96;
            MODE_QAM16: ncbps = 9'd192;
            default:    ncbps = 9'd288;
        endcase
    endfunction

endpackage

// File: rtl/demap_axis_slicer.sv
// rtl/demap_axis_slicer.sv - one-axis hard slicer (bA,bB,bC); weak flag only with DEMAP_WEAKCNT_EN
module demap_axis_slicer
    import ofdm_pkg::*;
#(
    parameter int W    = 16,
    parameter int FRAC = 8
`ifdef DEMAP_WEAKCNT_EN
    ,
    parameter int MARGIN = 32
`endif
) (
    input  logic signed [W-1:0] x,
    input  mode_t               mode,
    output logic [2:0]          bits
`ifdef DEMAP_WEAKCNT_EN
    ,
    output logic                weak
`endif
);

    localparam logic [W-1:0] U2 = W'(2 << FRAC);
    localparam logic [W-1:0] U4 = W'(4 << FRAC);
    localparam logic [W-1:0] U6 = W'(6 << FRAC);

    logic [W-1:0] a;

    // -(most negative) does not exist in W bits, so it saturates
    always_comb begin
        a = x;
        if (x[W-1]) begin
            if (x == {1'b1, {(W-1){1'b0}}}) a = {1'b0, {(W-1){1'b1}}};
            else                            a = -x;
        end
    end

    always_comb begin
        bits    = 3'b000;
        bits[0] = ~x[W-1];
        case (mode)
            MODE_QAM16: bits[1] = (a < U2);
            MODE_QAM64: begin
                bits[1] = (a < U4);
                bits[2] = (a >= U2) && (a < U6);
            end
            default: ;
        endcase
    end

`ifdef DEMAP_WEAKCNT_EN
    localparam logic [W-1:0] MG = W'(MARGIN);

    function automatic logic near(input logic [W-1:0] v, input logic [W-1:0] t);
        near = ((v >= t) ? (v - t) : (t - v)) < MG;
    endfunction

    always_comb begin
        weak = near(a, '0);
        if (mode == MODE_QAM16 || mode == MODE_QAM64) weak = weak | near(a, U2);
        if (mode == MODE_QAM64) weak = weak | near(a, U4) | near(a, U6);
    end
`endif

endmodule

// File: rtl/ofdm_demapper_serializer.sv
// rtl/ofdm_demapper_serializer.sv - hard demapper + bit serializer with symbol framing
// Optional near-boundary counter enabled by macro DEMAP_WEAKCNT_EN.
module ofdm_demapper_serializer #(
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int NSD  = 48
`ifdef DEMAP_WEAKCNT_EN
    ,
    parameter int MARGIN = 32
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic signed [W-1:0] in_i,
    input  logic signed [W-1:0] in_q,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_data,
    output logic                out_valid,
    output logic                out_last,
    output logic [5:0]          weak_cnt
);
    import ofdm_pkg::*;

    logic [2:0] rem;
    logic [4:0] shreg;
    logic [5:0] sc;
    mode_t      mode_q;
    logic       cur_last;

    mode_t      mode_eff;
    logic [2:0] nb;
    logic [5:0] bits;
    logic [2:0] bi, bq;
    logic       accept, sc_last;

    assign in_ready = (rem == 3'd0);
    assign accept   = in_valid && in_ready;
    assign sc_last  = (sc == 6'(NSD - 1));
    // mode input only matters on the first subcarrier of a symbol
    assign mode_eff = (sc == 6'd0) ? mode_t'(mode) : mode_q;
    assign nb       = nbpsc(mode_eff);

`ifdef DEMAP_WEAKCNT_EN
    logic wi, wq, weak;

    demap_axis_slicer #(.W(W), .FRAC(FRAC), .MARGIN(MARGIN)) u_slice_i (
        .x(in_i), .mode(mode_eff), .bits(bi), .weak(wi)
    );
    demap_axis_slicer #(.W(W), .FRAC(FRAC), .MARGIN(MARGIN)) u_slice_q (
        .x(in_q), .mode(mode_eff), .bits(bq), .weak(wq)
    );

    assign weak = wi | ((mode_eff != MODE_BPSK) & wq);
`else
    demap_axis_slicer #(.W(W), .FRAC(FRAC)) u_slice_i (
        .x(in_i), .mode(mode_eff), .bits(bi)
    );
    demap_axis_slicer #(.W(W), .FRAC(FRAC)) u_slice_q (
        .x(in_q), .mode(mode_eff), .bits(bq)
    );
`endif

    always_comb begin
        bits = 6'b000000;
        case (mode_eff)
            MODE_BPSK:  bits = {5'b00000, bi[0]};
            MODE_QPSK:  bits = {4'b0000, bq[0], bi[0]};
            MODE_QAM16: bits = {2'b00, bq[1:0], bi[1:0]};
            default:    bits = {bq, bi};
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem       <= 3'd0;
            shreg     <= 5'd0;
            sc        <= 6'd0;
            mode_q    <= MODE_BPSK;
            cur_last  <= 1'b0;
            out_data  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_data  <= bits[0];
            shreg     <= bits[5:1];
            rem       <= nb - 3'd1;
            out_valid <= 1'b1;
            out_last  <= (nb == 3'd1) && sc_last;
            cur_last  <= sc_last;
            sc        <= sc_last ? 6'd0 : sc + 6'd1;
            if (sc == 6'd0) mode_q <= mode_eff;
        end else if (rem != 3'd0) begin
            out_data  <= shreg[0];
            shreg     <= {1'b0, shreg[4:1]};
            rem       <= rem - 3'd1;
            out_valid <= 1'b1;
            out_last  <= (rem == 3'd1) && cur_last;
        end else begin
            out_data  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef DEMAP_WEAKCNT_EN
    logic [5:0] weak_acc, weak_pend;

    // total is parked in weak_pend until the symbol's last bit goes out
    always_ff @(posedge clock) begin
        if (reset) begin
            weak_acc  <= 6'd0;
            weak_pend <= 6'd0;
            weak_cnt  <= 6'd0;
        end else if (accept) begin
            if (sc_last) begin
                weak_acc  <= 6'd0;
                weak_pend <= weak_acc + {5'd0, weak};
                if (nb == 3'd1) weak_cnt <= weak_acc + {5'd0, weak};
            end else begin
                weak_acc <= weak_acc + {5'd0, weak};
            end
        end else if (rem == 3'd1 && cur_last) begin
            weak_cnt <= weak_pend;
        end
    end
`else
    assign weak_cnt = 6'd0;
`endif

endmodule
